// File: rtl/sysid_check_ctrl.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) over Avalon-MM and
// compares them against the build-time values, reporting match/mismatch/timeout.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1586355820,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] sys_id,
  output logic [31:0] sys_timestamp,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);

  // state  | meaning
  // IDLE   | no read in flight; waits for start or the autostart flag
  // RD_ID  | reading word 0 (ID)
  // RD_TS  | reading word 1 (build timestamp)
  // CMP    | both words captured; register the comparison results
  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

  state_t      r_state;
  logic [15:0] r_wait_cnt;
  logic        r_autostart;
  logic        r_avm_address;
  logic        r_avm_read;
  logic [31:0] r_sys_id;
  logic [31:0] r_sys_timestamp;
  logic        r_busy;
  logic        r_done;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;

  logic        w_expire;

  // Fires on the TIMEOUT_CYCLES-th consecutive stall of one read.
  assign w_expire = (TIMEOUT_CYCLES != 16'd0) &&
                    (r_wait_cnt == (TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_wait_cnt      <= 16'd0;
      r_autostart     <= AUTO_START;
      r_avm_address   <= 1'b0;
      r_avm_read      <= 1'b0;
      r_sys_id        <= 32'd0;
      r_sys_timestamp <= 32'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_id_match      <= 1'b0;
      r_ts_match      <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start || r_autostart) begin
            r_autostart   <= 1'b0;
            r_done        <= 1'b0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout     <= 1'b0;
            r_wait_cnt    <= 16'd0;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= RD_ID;
          end
        end
        RD_ID, RD_TS: begin
          if (!avm_waitrequest) begin
            r_wait_cnt <= 16'd0;
            if (r_state == RD_ID) begin
              r_sys_id      <= avm_readdata;
              r_avm_address <= 1'b1;
              r_state       <= RD_TS;
            end else begin
              r_sys_timestamp <= avm_readdata;
              r_avm_read      <= 1'b0;
              r_state         <= CMP;
            end
          end else if (w_expire) begin
            // Abandon the check; the word that never arrived keeps its old value.
            r_timeout  <= 1'b1;
            r_done     <= 1'b1;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_avm_read <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        CMP: begin
          r_id_match <= (r_sys_id == EXPECTED_ID);
          r_ts_match <= (r_sys_timestamp == EXPECTED_TS);
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign avm_address   = r_avm_address;
  assign avm_read      = r_avm_read;
  assign sys_id        = r_sys_id;
  assign sys_timestamp = r_sys_timestamp;
  assign busy          = r_busy;
  assign done          = r_done;
  assign id_match      = r_id_match;
  assign ts_match      = r_ts_match;
  assign timeout       = r_timeout;

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
Avalon-MM master controller that sequences reads of the system ID peripheral: word 0 (ID) and word 1 (build timestamp). It compares both words against the values expected at build time and reports match, mismatch or timeout to boot/status logic, so software and LEDs can refuse a mismatched FPGA image. It sits between the reset/boot logic and the sysid control slave, and is the only master on that slave.

Parameters:
EXPECTED_ID, 32'd0, value required at sysid address 0
EXPECTED_TS, 32'd1586355820, value required at sysid address 1
TIMEOUT_CYCLES, 16'd255, maximum wait-request cycles per read; 0 disables the timeout
AUTO_START, 1, 1 = run one check automatically after reset is released

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to run a check; ignored while busy
avm_address  output  1  sysid word select (0 = ID, 1 = timestamp)
avm_read  output  1  read strobe
avm_readdata  input  32  slave read data; valid in a cycle with avm_read=1 and avm_waitrequest=0
avm_waitrequest  input  1  slave stall
sys_id  output  32  captured word 0
sys_timestamp  output  32  captured word 1
busy  output  1  check in progress
done  output  1  sticky; result valid
id_match  output  1  sys_id == EXPECTED_ID
ts_match  output  1  sys_timestamp == EXPECTED_TS
timeout  output  1  a read exceeded TIMEOUT_CYCLES

Behaviour:
- Interface: one clock, clock. Reset is reset, asynchronous and active-high.
- All outputs are registered. Reset values: all outputs 0, state = IDLE, wait counter = 0, autostart flag = AUTO_START.
- Read protocol: zero-latency slave. A transfer completes in any cycle where avm_read=1 and avm_waitrequest=0. avm_readdata is captured in that cycle. avm_address is held stable while avm_read=1.
- States:
  - IDLE: avm_read=0, busy=0. Go to RD_ID when start=1 or the autostart flag is set. The autostart flag clears on that transition. On entry to RD_ID: clear done, id_match, ts_match and timeout; clear the wait counter.
  - RD_ID: avm_address=0, avm_read=1, busy=1.
    - On completion: sys_id <= avm_readdata, clear the wait counter, go to RD_TS.
    - On a stall cycle: increment the wait counter.
  - RD_TS: avm_address=1, otherwise same as RD_ID.
    - On completion: sys_timestamp <= avm_readdata, go to CMP.
  - CMP: avm_read=0, busy=1. Register id_match and ts_match (32-bit equality), set done=1, go to IDLE.
  - FAIL transition: in RD_ID or RD_TS, if TIMEOUT_CYCLES != 0 and the wait counter equals TIMEOUT_CYCLES-1 during a stall cycle, then:
    - set timeout=1, done=1, id_match=0, ts_match=0;
    - drop avm_read;
    - go to IDLE;
    - leave the sys_id and sys_timestamp registers unchanged for the word not yet read.
- Wait counter: 16 bits, saturating. With TIMEOUT_CYCLES=0 the FSM waits indefinitely.
- Latency with no stalls: start sampled at edge 0 -> avm_read=1/address 0 in cycle 1 -> address 1 in cycle 2 -> CMP in cycle 3 -> done=1 visible in cycle 4. Each stall cycle adds 1.
- start while busy=1 is ignored (not queued). start in the same cycle CMP returns to IDLE is ignored. start sampled in IDLE begins a new check, and done drops on the next cycle.
- The outputs done, id_match, ts_match and timeout hold until the next check begins or reset.
- Reset mid-operation: avm_read drops asynchronously. All results clear. If AUTO_START=1, a fresh check begins in the first cycle after reset deasserts.

Test Plan:
- AUTO_START=1, slave returns 0 / 1586355820, no stalls -> avm_read high cycles 1-2, done=1 in cycle 4, id_match=1, ts_match=1, timeout=0.
- Slave returns ID 0x00000001 -> done=1, id_match=0, ts_match=1, sys_id=0x00000001.
- avm_waitrequest high 3 cycles on address 1 -> address held at 1 for 4 cycles, done in cycle 7, matches=1.
- TIMEOUT_CYCLES=4, waitrequest stuck high on address 0 -> avm_read high exactly 4 cycles, then timeout=1, done=1, matches=0, busy=0.
- start pulses during busy, then a start pulse in IDLE -> only one extra check runs; done clears the cycle after accepted start and re-asserts 4 cycles later.
- Assert reset during RD_TS stall -> avm_read=0 immediately, all outputs 0; after release with AUTO_START=1 a full check completes with matches=1.
